// File: rtl/mcycle_ctrl.sv
// ============================================================================
// Module      : mcycle_ctrl
// Description : Sequencer for a multi-cycle shift-add multiply / restoring
//               divide datapath (load, WIDTH steps, done pulse, stall request).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcycle_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic             MCycleOp,
    input  logic             Operand2Zero,
    output logic             Busy,
    output logic             Load,
    output logic             Step,
    output logic             OpSel,
    output logic [CNT_W-1:0] Count,
    output logic             Done,
    output logic             DivByZero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic             op_sel_q;
    logic             op_sel_next;
    logic             dbz_q;
    logic             dbz_next;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= S_IDLE;
            count_q  <= '0;
            op_sel_q <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state    <= state_next;
            count_q  <= count_next;
            op_sel_q <= op_sel_next;
            dbz_q    <= dbz_next;
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = count_q;
        op_sel_next = op_sel_q;
        dbz_next    = dbz_q;
        Busy        = 1'b0;
        Load        = 1'b0;
        Step        = 1'b0;
        Done        = 1'b0;
        DivByZero   = 1'b0;

        case (state)
            S_IDLE: begin
                // Stall the requesting instruction in the same cycle it asks.
                Busy = Start;
                if (Start) begin
                    state_next  = S_LOAD;
                    op_sel_next = MCycleOp;
                end
            end
            S_LOAD: begin
                Busy       = 1'b1;
                Load       = 1'b1;
                count_next = '0;
                // Latched op, not the live input, decides the zero-divisor abort.
                if (op_sel_q && Operand2Zero) begin
                    state_next = S_DONE;
                    dbz_next   = 1'b1;
                end else begin
                    state_next = S_RUN;
                    dbz_next   = 1'b0;
                end
            end
            S_RUN: begin
                Busy = 1'b1;
                Step = 1'b1;
                if (count_q == LAST_STEP) begin
                    state_next = S_DONE;
                end else begin
                    count_next = count_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                Done       = 1'b1;
                DivByZero  = dbz_q;
                dbz_next   = 1'b0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign OpSel = op_sel_q;
    assign Count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_mcycle_ctrl.sv
// ============================================================================
// Module      : tb_mcycle_ctrl
// Description : Directed self-checking bench for mcycle_ctrl (WIDTH=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcycle_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       Start;
    logic       MCycleOp;
    logic       Operand2Zero;
    logic       Busy;
    logic       Load;
    logic       Step;
    logic       OpSel;
    logic [5:0] Count;
    logic       Done;
    logic       DivByZero;

    int n_pass  = 0;
    int n_total = 0;

    mcycle_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .Start        (Start),
        .MCycleOp     (MCycleOp),
        .Operand2Zero (Operand2Zero),
        .Busy         (Busy),
        .Load         (Load),
        .Step         (Step),
        .OpSel        (OpSel),
        .Count        (Count),
        .Done         (Done),
        .DivByZero    (DivByZero)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_cnt(input string tag, input logic [5:0] obs, input logic [5:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Checks Load/Step/Done/Busy together for one sampled cycle.
    task automatic chk_ctl(input string tag, input logic ld, input logic st,
                           input logic dn, input logic bz);
        chk({tag, ".load"}, Load, ld);
        chk({tag, ".step"}, Step, st);
        chk({tag, ".done"}, Done, dn);
        chk({tag, ".busy"}, Busy, bz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RESET = 1'b1; Start = 1'b0; MCycleOp = 1'b0; Operand2Zero = 1'b0;
        tick(); tick();
        RESET = 1'b0;

        // Reset state
        chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst.dbz", DivByZero, 1'b0);
        chk("rst.opsel", OpSel, 1'b0);
        chk_cnt("rst.count", Count, 6'd0);

        // Multiply, Start held high throughout
        Start = 1'b1; MCycleOp = 1'b0;
        #1 chk("mul.c0.busy", Busy, 1'b1);
        tick();
        chk_ctl("mul.c1", 1'b1, 1'b0, 1'b0, 1'b1);
        for (int c = 2; c <= 33; c++) begin
            tick();
            chk_ctl("mul.run", 1'b0, 1'b1, 1'b0, 1'b1);
            chk_cnt("mul.run.count", Count, 6'(c - 2));
            chk("mul.run.opsel", OpSel, 1'b0);
        end
        tick();
        chk_ctl("mul.c34", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("mul.c34.dbz", DivByZero, 1'b0);
        chk_cnt("mul.c34.count", Count, 6'd31);

        // Start still high: IDLE accepts at 35, Load at 36; this becomes a divide
        MCycleOp = 1'b1; Operand2Zero = 1'b0;
        tick();
        chk_ctl("div.c35", 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        Start = 1'b0;
        #1 chk_ctl("div.c36", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("div.c36.opsel", OpSel, 1'b1);
        for (int c = 0; c < 32; c++) begin
            tick();
            MCycleOp = ~MCycleOp;
            chk_ctl("div.run", 1'b0, 1'b1, 1'b0, 1'b1);
            chk_cnt("div.run.count", Count, 6'(c));
            chk("div.run.opsel", OpSel, 1'b1);
            chk("div.run.dbz", DivByZero, 1'b0);
        end
        tick();
        chk_ctl("div.done", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("div.done.dbz", DivByZero, 1'b0);
        chk("div.done.opsel", OpSel, 1'b1);
        tick();
        chk_ctl("div.idle", 1'b0, 1'b0, 1'b0, 1'b0);
        chk_cnt("div.idle.count", Count, 6'd31);

        // Divide by zero
        Start = 1'b1; MCycleOp = 1'b1; Operand2Zero = 1'b1;
        #1 chk("dbz.c0.busy", Busy, 1'b1);
        tick();
        Start = 1'b0; MCycleOp = 1'b0;
        #1 chk_ctl("dbz.c1", 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        chk_ctl("dbz.c2", 1'b0, 1'b0, 1'b1, 1'b0);
        chk("dbz.c2.dbz", DivByZero, 1'b1);
        chk_cnt("dbz.c2.count", Count, 6'd0);
        tick();
        chk_ctl("dbz.c3", 1'b0, 1'b0, 1'b0, 1'b0);
        chk("dbz.c3.dbz", DivByZero, 1'b0);
        Operand2Zero = 1'b0;

        // Reset mid-run at Count=10, Start held high
        Start = 1'b1; MCycleOp = 1'b1;
        tick();
        chk("rmid.c1.load", Load, 1'b1);
        for (int c = 2; c <= 12; c++) tick();
        chk_cnt("rmid.c12.count", Count, 6'd10);
        chk("rmid.c12.step", Step, 1'b1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        #1 chk_ctl("rmid.idle", 1'b0, 1'b0, 1'b0, 1'b1);
        chk_cnt("rmid.idle.count", Count, 6'd0);
        chk("rmid.idle.opsel", OpSel, 1'b0);
        MCycleOp = 1'b0;
        tick();
        chk_ctl("rmid.restart", 1'b1, 1'b0, 1'b0, 1'b1);
        Start = 1'b0;
        tick();
        chk("rmid.run.step", Step, 1'b1);
        chk_cnt("rmid.run.count", Count, 6'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
